muldiv_unit: RTL and testbench

- HI/LO multiply/divide unit for the 5-stage MIPS core, sitting beside the ALU in the Execute stage.
- It is the stall-request initiator whose request the hazard logic consumes. While a divide iterates, it raises stall_o, and the hazard logic uses it to freeze F/D/E and bubble M.
- Executes MULT/MULTU in one cycle and DIV/DIVU iteratively. It also services MTHI/MTLO and exposes HI/LO for MFHI/MFLO.

---
 rtl/muldiv_unit_pkg.sv | 24 ++
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit_div_core.sv | 116 +++++++++++
 rtl/muldiv_unit.sv | 81 ++++++++
 tb/tb_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, divider
// FSM encoding and the default datapath width.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } div_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
interface muldiv_unit_if
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             annul_i;
    logic             stall_o;
    logic             busy_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    // Pipeline side drives the request, observes stall and HI/LO.
    modport master (
        output start_i, op_i, a_i, b_i, annul_i,
        input  stall_o, busy_o, hi_o, lo_o
    );

    // Unit side.
    modport slave (
        input  start_i, op_i, a_i, b_i, annul_i,
        output stall_o, busy_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_unit_div_core.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up applied to the result of the final step.
module div_core
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,   // launch request, honoured only in idle
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             calc_o,
    output logic             done_o,    // final step this cycle; results valid
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_step, quo_step;

    // Operand magnitudes; DIVU passes raw values through.
    assign a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    // Restoring step: remainder needs one extra bit after the shift.
    assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
    assign no_borrow = rem_sh >= {1'b0, dvs_q};
    assign diff      = rem_sh[WIDTH-1:0] - dvs_q;
    assign rem_step  = no_borrow ? diff : rem_sh[WIDTH-1:0];
    assign quo_step  = {quo_q[WIDTH-2:0], no_borrow};

    assign hi_o   = neg_rem_q ? -rem_step : rem_step;
    assign lo_o   = neg_quo_q ? -quo_step : quo_step;
    assign busy_o = (state_q != StIdle);
    assign calc_o = (state_q == StCalc);

    // Next-state and datapath updates for the divide FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        done_o    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i && !annul_i) begin
                    rem_d     = '0;
                    quo_d     = a_mag;
                    dvs_d     = b_mag;
                    cnt_d     = '0;
                    neg_quo_d = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    neg_rem_d = signed_i & a_i[WIDTH-1];
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LastCnt) begin
                        done_o  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            // Held start is ignored here so the finished op is not relaunched.
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Divider state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit for the Execute stage. Single-cycle multiply and
// MTHI/MTLO; divides run in div_core while stall_o freezes the pipeline.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               div_req;
    logic               div_busy, div_calc, div_done;
    logic [WIDTH-1:0]   div_hi, div_lo;

    // Operands widened explicitly so the low 2*WIDTH bits are the exact product.
    assign prod_s = {{WIDTH{bus.a_i[WIDTH-1]}}, bus.a_i} * {{WIDTH{bus.b_i[WIDTH-1]}}, bus.b_i};
    assign prod_u = {{WIDTH{1'b0}}, bus.a_i} * {{WIDTH{1'b0}}, bus.b_i};

    assign div_req = bus.start_i && is_div_op(bus.op_i);

    div_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_div_core (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (div_req),
        .signed_i (bus.op_i == OP_DIV),
        .a_i      (bus.a_i),
        .b_i      (bus.b_i),
        .annul_i  (bus.annul_i),
        .busy_o   (div_busy),
        .calc_o   (div_calc),
        .done_o   (div_done),
        .hi_o     (div_hi),
        .lo_o     (div_lo)
    );

    // Stall covers the launch cycle and every iteration; annul drops it at once.
    assign bus.stall_o = !bus.annul_i && (div_calc || (!div_busy && div_req));
    assign bus.busy_o  = div_busy;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;

    // HI/LO write selection; annul suppresses every write in its cycle.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (!bus.annul_i) begin
            if (div_done) begin
                hi_d = div_hi;
                lo_d = div_lo;
            end else if (bus.start_i && !div_busy) begin
                case (bus.op_i)
                    OP_MULT:  {hi_d, lo_d} = prod_s;
                    OP_MULTU: {hi_d, lo_d} = prod_u;
                    OP_MTHI:  hi_d = bus.a_i;
                    OP_MTLO:  lo_d = bus.a_i;
                    default:  ;
                endcase
            end
        end
    end

    // HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// against an arithmetic reference model of HI/LO.
module tb_muldiv_unit;
    import mdu_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference HI/LO update from the architectural rules.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      ps;
        logic [63:0] pu;
        logic [31:0] ma, mb, q, r;
        case (op)
            OP_MULT: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = ps;
            end
            OP_MULTU: begin
                pu = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = pu;
            end
            OP_DIV, OP_DIVU: begin
                ma = (op == OP_DIV && a[31]) ? -a : a;
                mb = (op == OP_DIV && b[31]) ? -b : b;
                q  = (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
                r  = (mb == 0) ? ma : ma % mb;
                if (op == OP_DIV && (a[31] ^ b[31])) q = -q;
                if (op == OP_DIV && a[31]) r = -r;
                m_hi = r;
                m_lo = q;
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int stalls;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        #1;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.stall_o) break;
            stalls++;
            tick();
            // Operands are only sampled at launch.
            bus.a_i = $urandom();
            bus.b_i = $urandom();
            #1;
        end
        model_apply(op, a, b);
        check("div_stall_len", 64'(stalls), 64'd33);
        check("div_done_busy", 64'(bus.busy_o), 64'd1);
        check("div_hi", 64'(bus.hi_o), 64'(m_hi));
        check("div_lo", 64'(bus.lo_o), 64'(m_lo));
        tick();
        bus.start_i = 1'b0;
        #1;
        check("div_no_relaunch", 64'(bus.busy_o), 64'd0);
        check("div_after_stall", 64'(bus.stall_o), 64'd0);
    endtask

    task automatic run_simple(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        #1;
        check("simple_stall", 64'(bus.stall_o), 64'd0);
        tick();
        bus.start_i = 1'b0;
        #1;
        model_apply(op, a, b);
        check("simple_hi", 64'(bus.hi_o), 64'(m_hi));
        check("simple_lo", 64'(bus.lo_o), 64'(m_lo));
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == OP_DIV || op == OP_DIVU) run_div(op, a, b);
        else                               run_simple(op, a, b);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        total = 0;
        bad   = 0;
        m_hi  = '0;
        m_lo  = '0;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.op_i    = 3'd7;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.annul_i = 1'b0;
        repeat (2) tick();
        check("reset_hi", 64'(bus.hi_o), 64'd0);
        check("reset_lo", 64'(bus.lo_o), 64'd0);
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        check("reset_stall", 64'(bus.stall_o), 64'd0);
        rst_n = 1'b1;
        tick();

        run_div(OP_DIVU, 32'd100, 32'd7);
        check("divu_100_7_lo", 64'(bus.lo_o), 64'd14);
        check("divu_100_7_hi", 64'(bus.hi_o), 64'd2);
        run_div(OP_DIV, -32'sd7, 32'd2);
        check("div_m7_2_lo", 64'(bus.lo_o), 64'hFFFF_FFFD);
        check("div_m7_2_hi", 64'(bus.hi_o), 64'hFFFF_FFFF);
        run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_min_m1_lo", 64'(bus.lo_o), 64'h8000_0000);
        check("div_min_m1_hi", 64'(bus.hi_o), 64'd0);
        run_div(OP_DIVU, 32'h1234, 32'd0);
        check("divu_by0_lo", 64'(bus.lo_o), 64'hFFFF_FFFF);
        check("divu_by0_hi", 64'(bus.hi_o), 64'h1234);
        run_div(OP_DIV, -32'sd20, 32'd0);

        run_simple(OP_MULT, -32'sd3, 32'd5);
        check("mult_hi", 64'(bus.hi_o), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.lo_o), 64'hFFFF_FFF1);
        run_simple(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        check("multu_hi", 64'(bus.hi_o), 64'd1);
        check("multu_lo", 64'(bus.lo_o), 64'hFFFF_FFFE);
        run_simple(OP_MTHI, 32'hABCD, 32'd0);
        check("mthi", 64'(bus.hi_o), 64'hABCD);
        run_simple(OP_MTLO, 32'h5A5A, 32'd0);

        // Annul at CALC step 5.
        bus.start_i = 1'b1;
        bus.op_i    = OP_DIVU;
        bus.a_i     = 32'd999;
        bus.b_i     = 32'd4;
        #1;
        repeat (6) tick();
        check("annul_pre_stall", 64'(bus.stall_o), 64'd1);
        bus.annul_i = 1'b1;
        #1;
        check("annul_stall", 64'(bus.stall_o), 64'd0);
        tick();
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check("annul_busy", 64'(bus.busy_o), 64'd0);
        check("annul_hi", 64'(bus.hi_o), 64'(m_hi));
        check("annul_lo", 64'(bus.lo_o), 64'(m_lo));

        // Annul on the launch cycle.
        bus.start_i = 1'b1;
        bus.op_i    = OP_DIV;
        bus.annul_i = 1'b1;
        #1;
        check("annul_launch_stall", 64'(bus.stall_o), 64'd0);
        tick();
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        #1;
        check("annul_launch_busy", 64'(bus.busy_o), 64'd0);

        // Annul coinciding with MTLO.
        bus.start_i = 1'b1;
        bus.op_i    = OP_MTLO;
        bus.a_i     = 32'hDEAD;
        bus.annul_i = 1'b1;
        #1;
        tick();
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        #1;
        check("annul_mtlo", 64'(bus.lo_o), 64'(m_lo));

        // Reset mid-CALC after 10 steps.
        bus.start_i = 1'b1;
        bus.op_i    = OP_DIVU;
        bus.a_i     = 32'd1000;
        bus.b_i     = 32'd3;
        #1;
        repeat (11) tick();
        bus.start_i = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("rst_mid_busy", 64'(bus.busy_o), 64'd0);
        check("rst_mid_stall", 64'(bus.stall_o), 64'd0);
        check("rst_mid_hi", 64'(bus.hi_o), 64'd0);
        check("rst_mid_lo", 64'(bus.lo_o), 64'd0);
        m_hi = '0;
        m_lo = '0;
        tick();
        rst_n = 1'b1;
        tick();
        run_div(OP_DIVU, 32'h55, 32'd5);

        // Random ops against the model.
        for (int n = 0; n < 30; n++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom();
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(1, 15));
            run_op(rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
